// File: rtl/arb_mux_rr.sv
// Round-robin N:1 arbiter/mux with a one-beat registered output stage.
// Define ARB_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module arb_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  // Handshake: a beat moves on any side exactly when valid && ready at a rising edge;
  // valid never depends on ready, and in_ready is only ever asserted for the winner.

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  winner;
  logic [SELW-1:0]  next_ptr;
  logic             found;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] win_data;
  int               idx;

`ifdef ARB_MUX_LOCK_EN
  logic             locked;
  logic [SELW-1:0]  lock_ch;
`else
  logic             unused_last;
  assign unused_last = ^in_last;
`endif

  assign load = !out_valid || out_ready;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = SELW'(idx);
      end
    end
`ifdef ARB_MUX_LOCK_EN
    // A locked channel owns the output even while it has nothing to send.
    if (locked) begin
      found  = in_valid[lock_ch];
      winner = lock_ch;
    end
`endif
  end

  assign xfer     = found && load;
  assign win_data = in_data[int'(winner)*WIDTH +: WIDTH];
  assign next_ptr = (int'(winner) == NCH-1) ? '0 : winner + 1'b1;

  always_comb begin
    in_ready = '0;
    if (xfer && rst_n) in_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_sel   <= winner;
`ifdef ARB_MUX_LOCK_EN
      if (in_last[winner]) ptr <= next_ptr;
`else
      ptr       <= next_ptr;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= !in_last[winner];
      lock_ch <= winner;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_rr.sv
// Randomized scoreboard bench for arb_mux_rr (NCH=4, WIDTH=32, lock disabled).
module tb_arb_mux_rr;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;

  arb_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: expected {sel, data} in grant order, plus the reference model
  logic [SELW+WIDTH-1:0] exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  m_ptr  = 0;
  bit  m_valid = 1'b0;
  bit  mon_en = 1'b0;
  bit  fixed_data = 1'b0;
  int  gcnt[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
  endtask

  // one stimulus cycle: drive at negedge, then advance the model to the state after the next edge
  task automatic drive_cycle(input logic [NCH-1:0] v, input logic r);
    int win;
    bit load;
    logic [NCH-1:0] exp_rdy;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    in_last   = NCH'($urandom);
    for (int i = 0; i < NCH; i++)
      in_data[i*WIDTH +: WIDTH] = fixed_data ? WIDTH'(32'h10 + i) : WIDTH'($urandom);
    #2;
    load = !m_valid || r;
    win  = -1;
    for (int k = 0; k < NCH; k++)
      if (win < 0 && v[(m_ptr + k) % NCH]) win = (m_ptr + k) % NCH;
    exp_rdy = '0;
    if (load && win >= 0) exp_rdy[win] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (load && win >= 0) begin
      d = in_data[win*WIDTH +: WIDTH];
      exp_q.push_back({SELW'(win), d});
      m_ptr   = (win + 1) % NCH;
      m_valid = 1'b1;
    end else if (r) begin
      m_valid = 1'b0;
    end
  endtask

  // monitor: checks the held beat each cycle and retires it when it is consumed
  initial begin
    logic [SELW+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("beat_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat_sel_data", 64'({out_sel, out_data}), 64'(e));
          end
          gcnt[out_sel]++;
        end
      end
    end
  end

  initial begin
    int mn, mx;
    rst_n = 1'b0; in_valid = '1; in_data = '1; in_last = '0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) gcnt[i] = 0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid = '0;
    mon_en = 1'b1;

    // two channels alternating at full rate with known data
    fixed_data = 1'b1;
    repeat (6) drive_cycle(4'b0101, 1'b1);
    fixed_data = 1'b0;

    // stall with every channel requesting, then resume
    drive_cycle(4'b1111, 1'b0);
    repeat (5) drive_cycle(4'b1111, 1'b0);
    repeat (3) drive_cycle(4'b1111, 1'b1);

    // steer ptr to 3 and exercise the wrap to channel 0
    drive_cycle(4'b0000, 1'b1);
    drive_cycle(4'b0000, 1'b1);
    drive_cycle(4'b0100, 1'b1);
    drive_cycle(4'b1001, 1'b1);
    drive_cycle(4'b1001, 1'b1);
    drive_cycle(4'b0110, 1'b1);

    // idle cycles must not move ptr
    repeat (3) drive_cycle(4'b0000, 1'b1);
    drive_cycle(4'b1111, 1'b1);

    // fully random traffic
    repeat (300) drive_cycle(NCH'($urandom), 1'($urandom_range(0, 1)));

    // asynchronous reset between edges while a beat is held
    drive_cycle(4'b0010, 1'b0);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_data", 64'(out_data), 64'(0));
    check("mid_rst_out_sel", 64'(out_sel), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    in_valid = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1; in_valid = '0;
    mon_en = 1'b1;
    drive_cycle(4'b1010, 1'b1);
    drive_cycle(4'b0000, 1'b1);

    // fairness: everyone always requesting, random backpressure
    drive_cycle(4'b0000, 1'b1);
    for (int i = 0; i < NCH; i++) gcnt[i] = 0;
    repeat (1000) drive_cycle(4'b1111, 1'($urandom_range(0, 1)));
    drive_cycle(4'b0000, 1'b1);
    drive_cycle(4'b0000, 1'b1);
    drive_cycle(4'b0000, 1'b1);
    mn = gcnt[0]; mx = gcnt[0];
    for (int i = 1; i < NCH; i++) begin
      if (gcnt[i] < mn) mn = gcnt[i];
      if (gcnt[i] > mx) mx = gcnt[i];
    end
    check("fair_spread_le1", 64'(mx - mn <= 1), 64'(1));
    check("fair_nonzero", 64'(mn > 100), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/arb_mux_rr.md
ARB_MUX_RR -- requirements
Module: arb_mux_rr

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel in bits.
REQ-002 Parameter NCH, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, width of out_sel; SHALL equal ceil(log2(NCH)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-007 in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
REQ-008 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_last  input  NCH  per-channel end-of-burst marker; used only with ARB_MUX_LOCK_EN.
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_data  output  WIDTH  registered data of the held beat.
REQ-013 out_sel  output  SELW  index of the channel that sourced the held beat.

Function
REQ-014 Load condition: load = !out_valid || out_ready; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-015 Arbitration: round-robin; winner = first i with in_valid[i] set, searching from ptr upward, wrapping NCH-1 -> 0.
REQ-016 in_ready[winner] = load; every other in_ready bit = 0; in_ready is combinational from in_valid, ptr, lock state and out_valid/out_ready.
REQ-017 On a transfer: out_data <= winning in_data, out_sel <= winner, out_valid <= 1, ptr <= winner+1 modulo NCH.
REQ-018 Latency: one cycle from transfer to out_valid/out_data visible.
REQ-019 Throughput: one beat per cycle when out_ready held high; simultaneous drain and load in the same cycle SHALL not insert a bubble.
REQ-020 Drain without load (out_valid && out_ready, no in_valid): out_valid <= 0; out_data and out_sel hold their last values.
REQ-021 Stall (out_valid && !out_ready): all in_ready = 0; out_valid, out_data, out_sel, ptr held stable.
REQ-022 No in_valid set: no transfer, ptr unchanged.
REQ-023 A channel with in_valid held high SHALL be granted within NCH transfers (no starvation).
REQ-024 in_valid high with in_ready low SHALL not alter any state.

Reset
REQ-025 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, lock state cleared, in_ready = 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard the held beat; no beat is produced from pre-reset inputs after release.
REQ-027 First arbitration after reset release SHALL start from channel 0.

Configuration
REQ-028 Macro ARB_MUX_LOCK_EN selects burst-locked arbitration.
REQ-029 With ARB_MUX_LOCK_EN defined: a transfer with in_last[winner] = 0 sets lock to that channel; while locked only that channel may win, others see in_ready = 0 even if the locked channel is idle; a transfer with in_last = 1 clears lock and advances ptr as REQ-017.
REQ-030 With ARB_MUX_LOCK_EN defined: while locked, ptr SHALL not advance.
REQ-031 Without ARB_MUX_LOCK_EN: in_last ignored, no lock state exists, arbitration per beat as REQ-015..REQ-017.

Verification
REQ-032 NCH=4, WIDTH=32, reset release, in_valid=4'b0101, data ch0=0x10, ch2=0x12, out_ready=1 -> out_sel sequence 0,2,0,2, out_data 0x10,0x12,..., one beat per cycle.
REQ-033 in_valid=4'b1111, out_ready=0 for 5 cycles after first beat -> out_data/out_sel constant, in_ready=0 throughout; on out_ready=1, next grant is ptr channel.
REQ-034 ptr=3, in_valid=4'b1001 -> channel 3 granted, then channel 0 (wrap); ptr returns to 1.
REQ-035 Assert rst_n=0 mid-stream between clock edges with out_valid=1 -> out_valid, out_data, out_sel go 0 immediately; after release first grant from channel 0.
REQ-036 With ARB_MUX_LOCK_EN: ch1 sends 3 beats, in_last on third, ch2 valid throughout -> out_sel 1,1,1,2; ch2 in_ready=0 during the burst including idle cycles of ch1.
REQ-037 Random valid/ready, all channels always valid, 1000 cycles -> per-channel grant counts differ by at most 1 (lock disabled).
